// File: rtl/ifetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ifetch_ctrl
//  Description : Instruction-fetch sequencer for the pipelined CPU.
//                Owns the program counter, drives the (combinational)
//                instruction ROM address and holds the IF/ID pipeline
//                register. Selects the next PC among sequential, branch,
//                jump, jr, interrupt and exception sources, applies
//                stalls and flushes, captures the EPC and pulses the
//                interrupt / exception acknowledges. PC[31] is the kernel
//                bit.
//
//  Ports:
//    clk              in   1   system clock, rising edge
//    reset            in   1   synchronous, active-high
//    rom_addr_o       out  32  fetch address (always equals pc)
//    rom_data_i       in   32  instruction word at rom_addr_o, same cycle
//    stall_i          in   1   load-use hazard: hold pc and IF/ID
//    branch_taken_i   in   1   branch resolved taken in ID
//    branch_target_i  in   32  branch target computed in ID
//    jump_i           in   1   J/JAL in ID
//    jump_index_i     in   26  instr[25:0] of J/JAL
//    jr_i             in   1   JR/JALR in ID
//    jr_target_i      in   32  register value for JR/JALR
//    irq_i            in   1   level-sensitive interrupt request
//    exc_i            in   1   undefined instruction detected in ID
//    id_instr_o       out  32  IF/ID instruction
//    id_pc_plus4_o    out  32  IF/ID PC+4
//    id_valid_o       out  1   IF/ID holds a real instruction
//    epc_o            out  32  return address captured on irq/exc
//    irq_ack_o        out  1   one-cycle pulse, interrupt taken
//    exc_ack_o        out  1   one-cycle pulse, exception taken
//    kernel_o         out  1   kernel mode, equals pc[31]
//
//  Revision    : 1.0  initial release
// ============================================================================
module ifetch_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h8000_0000,
    parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
    parameter logic [31:0] EXC_VEC   = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_data_i,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [25:0] jump_index_i,
    input  logic        jr_i,
    input  logic [31:0] jr_target_i,
    input  logic        irq_i,
    input  logic        exc_i,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_plus4_o,
    output logic        id_valid_o,
    output logic [31:0] epc_o,
    output logic        irq_ack_o,
    output logic        exc_ack_o,
    output logic        kernel_o
);

    // ------------------------------------------------------------------
    // Next-PC source encoding, listed from highest to lowest priority.
    // ------------------------------------------------------------------
    localparam logic [2:0] c_SEL_EXC    = 3'd0;
    localparam logic [2:0] c_SEL_IRQ    = 3'd1;
    localparam logic [2:0] c_SEL_JR     = 3'd2;
    localparam logic [2:0] c_SEL_JUMP   = 3'd3;
    localparam logic [2:0] c_SEL_BRANCH = 3'd4;
    localparam logic [2:0] c_SEL_HOLD   = 3'd5;
    localparam logic [2:0] c_SEL_SEQ    = 3'd6;

    localparam logic [31:0] c_ZERO32 = 32'h0000_0000;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] pc_q,          pc_d;
    logic [31:0] id_instr_q,    id_instr_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
    logic        id_valid_q,    id_valid_d;
    logic [31:0] epc_q,         epc_d;
    logic        irq_ack_q,     irq_ack_d;
    logic        exc_ack_q,     exc_ack_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic        w_kernel;
    logic        w_id_ctrl_flow;
    logic        w_take_exc;
    logic        w_take_irq;
    logic        w_trap;
    logic [2:0]  w_sel;
    logic        w_redirect;
    logic [30:0] w_pc_low_inc;
    logic [31:0] w_pc_seq;
    logic [31:0] w_jr_pc;
    logic [31:0] w_jump_pc;
    logic [31:0] w_branch_pc;
    logic [31:0] w_trap_epc;

    assign w_kernel = pc_q[31];

    // Any control-flow change resolved in ID this cycle; an interrupt
    // must not be taken on top of one of these.
    assign w_id_ctrl_flow = branch_taken_i | jump_i | jr_i;

    // An exception is taken unconditionally, even under a stall.
    assign w_take_exc = exc_i;

    // The interrupt is deferred (the source keeps the level asserted)
    // while in kernel mode, while stalled, while ID is redirecting, or
    // while an exception claims the same cycle.
    assign w_take_irq = irq_i & ~exc_i & ~w_kernel & ~stall_i & ~w_id_ctrl_flow;

    assign w_trap = w_take_exc | w_take_irq;

    // Sequential increment wraps inside [30:0]; the kernel bit is carried
    // over unchanged so user code can never fall into kernel space.
    assign w_pc_low_inc = pc_q[30:0] + 31'd4;
    assign w_pc_seq     = {pc_q[31], w_pc_low_inc};

    // jr may clear the kernel bit but never set it.
    assign w_jr_pc = {pc_q[31] & jr_target_i[31], jr_target_i[30:0]};

    // Pseudo-direct jump: region bits come from the ID instruction's PC+4.
    assign w_jump_pc = {id_pc_plus4_q[31:28], jump_index_i, 2'b00};

    // Branches stay in the mode of the instruction that issued them.
    assign w_branch_pc = {id_pc_plus4_q[31], branch_target_i[30:0]};

    // The instruction sitting in ID is discarded by the trap, so the
    // handler must return to it; with a bubble in ID, return to the
    // instruction currently being fetched.
    assign w_trap_epc = id_valid_q ? (id_pc_plus4_q - 32'd4) : pc_q;

    // ------------------------------------------------------------------
    // Next-PC source selection
    // ------------------------------------------------------------------
    always_comb begin
        w_sel = c_SEL_SEQ;
        if (w_take_exc) begin
            w_sel = c_SEL_EXC;
        end else if (w_take_irq) begin
            w_sel = c_SEL_IRQ;
        end else if (jr_i) begin
            w_sel = c_SEL_JR;
        end else if (jump_i) begin
            w_sel = c_SEL_JUMP;
        end else if (branch_taken_i) begin
            w_sel = c_SEL_BRANCH;
        end else if (stall_i) begin
            w_sel = c_SEL_HOLD;
        end
    end

    // Every source other than hold/sequential redirects the fetch stream
    // and therefore overrides a stall.
    assign w_redirect = (w_sel != c_SEL_HOLD) && (w_sel != c_SEL_SEQ);

    // ------------------------------------------------------------------
    // PC and IF/ID next state
    // ------------------------------------------------------------------
    always_comb begin
        pc_d          = pc_q;
        id_instr_d    = id_instr_q;
        id_pc_plus4_d = id_pc_plus4_q;
        id_valid_d    = id_valid_q;

        case (w_sel)
            c_SEL_EXC:    pc_d = EXC_VEC;
            c_SEL_IRQ:    pc_d = IRQ_VEC;
            c_SEL_JR:     pc_d = w_jr_pc;
            c_SEL_JUMP:   pc_d = w_jump_pc;
            c_SEL_BRANCH: pc_d = w_branch_pc;
            c_SEL_HOLD:   pc_d = pc_q;
            default:      pc_d = w_pc_seq;
        endcase

        if (w_redirect) begin
            // No delay slot: the wrong-path fetch becomes a bubble.
            id_instr_d    = c_ZERO32;
            id_pc_plus4_d = c_ZERO32;
            id_valid_d    = 1'b0;
        end else if (w_sel == c_SEL_SEQ) begin
            id_instr_d    = rom_data_i;
            id_pc_plus4_d = w_pc_seq;
            id_valid_d    = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // EPC and acknowledge next state
    // ------------------------------------------------------------------
    always_comb begin
        epc_d     = epc_q;
        irq_ack_d = w_take_irq;
        exc_ack_d = w_take_exc;
        if (w_trap) begin
            epc_d = w_trap_epc;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_VEC;
            id_instr_q    <= c_ZERO32;
            id_pc_plus4_q <= c_ZERO32;
            id_valid_q    <= 1'b0;
            epc_q         <= c_ZERO32;
            irq_ack_q     <= 1'b0;
            exc_ack_q     <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            id_instr_q    <= id_instr_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            id_valid_q    <= id_valid_d;
            epc_q         <= epc_d;
            irq_ack_q     <= irq_ack_d;
            exc_ack_q     <= exc_ack_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rom_addr_o    = pc_q;
    assign kernel_o      = w_kernel;
    assign id_instr_o    = id_instr_q;
    assign id_pc_plus4_o = id_pc_plus4_q;
    assign id_valid_o    = id_valid_q;
    assign epc_o         = epc_q;
    assign irq_ack_o     = irq_ack_q;
    assign exc_ack_o     = exc_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ifetch_ctrl
//  Description : Self-checking bench for ifetch_ctrl. Directed scenario
//                tasks compare against hand-derived constants; a random
//                phase compares every output against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        stall, branch_taken, jump, jr, irq, exc;
    logic [31:0] branch_target, jr_target;
    logic [25:0] jump_index;
    logic [31:0] id_instr, id_pc_plus4, epc;
    logic        id_valid, irq_ack, exc_ack, kernel;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rom [0:255];
    assign rom_data = rom[rom_addr[9:2]];

    // Behavioural model state
    logic [31:0] m_pc, m_instr, m_pc4, m_epc;
    logic        m_valid, m_iack, m_eack;

    always #5 clk = ~clk;

    ifetch_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .rom_addr_o      (rom_addr),
        .rom_data_i      (rom_data),
        .stall_i         (stall),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .jump_i          (jump),
        .jump_index_i    (jump_index),
        .jr_i            (jr),
        .jr_target_i     (jr_target),
        .irq_i           (irq),
        .exc_i           (exc),
        .id_instr_o      (id_instr),
        .id_pc_plus4_o   (id_pc_plus4),
        .id_valid_o      (id_valid),
        .epc_o           (epc),
        .irq_ack_o       (irq_ack),
        .exc_ack_o       (exc_ack),
        .kernel_o        (kernel)
    );

    // Model: one clock edge computed from the textual rules.
    task automatic model_step();
        logic [31:0] seq, nxt_pc, trap_ret;
        logic        user, flush, irq_ok;
        seq      = (m_pc & 32'h8000_0000) | ((m_pc + 32'd4) & 32'h7FFF_FFFF);
        user     = (m_pc < 32'h8000_0000);
        irq_ok   = irq && user && !stall && !branch_taken && !jump && !jr;
        trap_ret = m_valid ? (m_pc4 - 32'd4) : m_pc;
        flush    = 1'b1;
        nxt_pc   = m_pc;
        m_iack   = 1'b0;
        m_eack   = 1'b0;
        if (reset) begin
            m_pc = 32'h8000_0000; m_instr = 0; m_pc4 = 0; m_valid = 0;
            m_epc = 0;
            return;
        end
        if (exc) begin
            nxt_pc = 32'h8000_0008; m_epc = trap_ret; m_eack = 1'b1;
        end else if (irq_ok) begin
            nxt_pc = 32'h8000_0004; m_epc = trap_ret; m_iack = 1'b1;
        end else if (jr) begin
            nxt_pc = (jr_target & 32'h7FFF_FFFF) | (m_pc & jr_target & 32'h8000_0000);
        end else if (jump) begin
            nxt_pc = (m_pc4 & 32'hF000_0000) | (32'(jump_index) * 4);
        end else if (branch_taken) begin
            nxt_pc = (m_pc4 & 32'h8000_0000) | (branch_target & 32'h7FFF_FFFF);
        end else if (stall) begin
            flush = 1'b0;
        end else begin
            flush   = 1'b0;
            m_instr = rom[m_pc[9:2]];
            m_pc4   = seq;
            m_valid = 1'b1;
            nxt_pc  = seq;
        end
        if (flush) begin
            m_instr = 0; m_pc4 = 0; m_valid = 0;
        end
        m_pc = nxt_pc;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clr_inputs();
        reset = 0; stall = 0; branch_taken = 0; jump = 0; jr = 0;
        irq = 0; exc = 0; branch_target = 0; jr_target = 0; jump_index = 0;
    endtask

    task automatic do_reset();
        clr_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset();
        clr_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
        n_checks++; if (rom_addr !== 32'h8000_0000) begin n_fail++; $display("FAIL reset_pc: got %h want %h", rom_addr, 32'h8000_0000); end
        n_checks++; if (id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", id_valid); end
        n_checks++; if ({id_instr, id_pc_plus4, epc} !== 96'd0) begin n_fail++; $display("FAIL reset_regs: got %h %h %h want 0", id_instr, id_pc_plus4, epc); end
        n_checks++; if ({irq_ack, exc_ack, kernel} !== 3'b001) begin n_fail++; $display("FAIL reset_flags: got %b want 001", {irq_ack, exc_ack, kernel}); end
        tick();
        n_checks++; if (id_instr !== rom[0]) begin n_fail++; $display("FAIL first_fetch_instr: got %h want %h", id_instr, rom[0]); end
        n_checks++; if (id_pc_plus4 !== 32'h8000_0004 || id_valid !== 1'b1) begin n_fail++; $display("FAIL first_fetch_pc4: got %h/%b want 80000004/1", id_pc_plus4, id_valid); end
    endtask

    task automatic test_stall();
        do_reset();
        jr = 1; jr_target = 32'h0000_0100;
        tick();
        jr = 0; stall = 1;
        tick();
        tick();
        n_checks++; if (rom_addr !== 32'h100 || id_valid !== 1'b0 || id_instr !== 0) begin n_fail++; $display("FAIL stall_bubble: got pc %h valid %b instr %h want 100/0/0", rom_addr, id_valid, id_instr); end
        stall = 0;
        tick();
        n_checks++; if (rom_addr !== 32'h104 || id_instr !== rom[64] || id_pc_plus4 !== 32'h104) begin n_fail++; $display("FAIL stall_release: got pc %h instr %h pc4 %h want 104/%h/104", rom_addr, id_instr, id_pc_plus4, rom[64]); end
        stall = 1;
        tick();
        tick();
        n_checks++; if (rom_addr !== 32'h104 || id_instr !== rom[64] || id_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold: got pc %h instr %h valid %b want 104/%h/1", rom_addr, id_instr, id_valid, rom[64]); end
        stall = 0;
        tick();
        n_checks++; if (rom_addr !== 32'h108 || id_instr !== rom[65]) begin n_fail++; $display("FAIL stall_resume: got pc %h instr %h want 108/%h", rom_addr, id_instr, rom[65]); end
    endtask

    task automatic test_jump_jr();
        do_reset();
        tick();
        jump = 1; jump_index = 26'h2F;
        tick();
        jump = 0;
        n_checks++; if (rom_addr !== 32'h8000_00BC || id_valid !== 1'b0 || kernel !== 1'b1) begin n_fail++; $display("FAIL jump_kernel: got pc %h valid %b k %b want 800000bc/0/1", rom_addr, id_valid, kernel); end
        jr = 1; jr_target = 32'h0000_005C;
        tick();
        jr = 0;
        n_checks++; if (rom_addr !== 32'h5C || kernel !== 1'b0) begin n_fail++; $display("FAIL jr_exit_kernel: got pc %h k %b want 5c/0", rom_addr, kernel); end
    endtask

    task automatic test_jr_no_kernel();
        jr = 1; jr_target = 32'h8000_0010;
        tick();
        jr = 0;
        n_checks++; if (rom_addr !== 32'h10 || kernel !== 1'b0) begin n_fail++; $display("FAIL jr_no_kernel: got pc %h k %b want 10/0", rom_addr, kernel); end
    endtask

    task automatic test_irq();
        do_reset();
        jr = 1; jr_target = 32'h104;
        tick();
        jr = 0;
        tick();
        irq = 1;
        tick();
        n_checks++; if (rom_addr !== 32'h8000_0004 || epc !== 32'h104 || irq_ack !== 1'b1 || id_valid !== 1'b0) begin n_fail++; $display("FAIL irq_take: got pc %h epc %h ack %b valid %b want 80000004/104/1/0", rom_addr, epc, irq_ack, id_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (irq_ack !== 1'b0) begin n_fail++; $display("FAIL irq_masked: cycle %0d got ack %b want 0", i, irq_ack); end
        end
        jr = 1; jr_target = 32'h200;
        tick();
        jr = 0; jump = 1; jump_index = 26'h40;
        tick();
        jump = 0;
        n_checks++; if (rom_addr !== 32'h100 || irq_ack !== 1'b0) begin n_fail++; $display("FAIL irq_defer_jump: got pc %h ack %b want 100/0", rom_addr, irq_ack); end
        tick();
        irq = 0;
        n_checks++; if (rom_addr !== 32'h8000_0004 || irq_ack !== 1'b1 || epc !== 32'h100) begin n_fail++; $display("FAIL irq_after_defer: got pc %h ack %b epc %h want 80000004/1/100", rom_addr, irq_ack, epc); end
    endtask

    task automatic test_exc();
        do_reset();
        jr = 1; jr_target = 32'h1FC;
        tick();
        jr = 0;
        tick();
        exc = 1; irq = 1; stall = 1;
        tick();
        exc = 0; irq = 0; stall = 0;
        n_checks++; if (rom_addr !== 32'h8000_0008 || epc !== 32'h1FC || exc_ack !== 1'b1 || irq_ack !== 1'b0) begin n_fail++; $display("FAIL exc_priority: got pc %h epc %h eack %b iack %b want 80000008/1fc/1/0", rom_addr, epc, exc_ack, irq_ack); end
        reset = 1;
        tick();
        reset = 0;
        n_checks++; if (rom_addr !== 32'h8000_0000 || epc !== 0 || exc_ack !== 1'b0 || id_valid !== 1'b0 || id_pc_plus4 !== 0) begin n_fail++; $display("FAIL reset_in_ack: got pc %h epc %h eack %b valid %b want 80000000/0/0/0", rom_addr, epc, exc_ack, id_valid); end
    endtask

    task automatic test_branch_wrap();
        do_reset();
        tick();
        branch_taken = 1; branch_target = 32'h0000_1234;
        tick();
        branch_taken = 0;
        n_checks++; if (rom_addr !== 32'h8000_1234) begin n_fail++; $display("FAIL branch_kernel: got pc %h want 80001234", rom_addr); end
        jr = 1; jr_target = 32'h7FFF_FFFC;
        tick();
        jr = 0;
        tick();
        n_checks++; if (rom_addr !== 32'h0 || id_pc_plus4 !== 32'h0 || id_instr !== rom[255] || id_valid !== 1'b1) begin n_fail++; $display("FAIL pc_wrap: got pc %h pc4 %h instr %h want 0/0/%h", rom_addr, id_pc_plus4, id_instr, rom[255]); end
        branch_taken = 1; branch_target = 32'h8000_0040;
        tick();
        branch_taken = 0;
        n_checks++; if (rom_addr !== 32'h40 || kernel !== 1'b0) begin n_fail++; $display("FAIL branch_user: got pc %h k %b want 40/0", rom_addr, kernel); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset         = ($urandom_range(0, 99) < 1);
            exc           = ($urandom_range(0, 99) < 3);
            irq           = ($urandom_range(0, 99) < 25);
            jr            = ($urandom_range(0, 99) < 6);
            jump          = ($urandom_range(0, 99) < 6);
            branch_taken  = ($urandom_range(0, 99) < 8);
            stall         = ($urandom_range(0, 99) < 15);
            jr_target     = $urandom() & 32'hFFFF_FFFC;
            branch_target = $urandom() & 32'hFFFF_FFFC;
            jump_index    = 26'($urandom());
            tick();
            n_checks++; if (rom_addr !== m_pc || kernel !== m_pc[31]) begin n_fail++; $display("FAIL rnd_pc: cycle %0d got %h k %b want %h", i, rom_addr, kernel, m_pc); end
            n_checks++; if (id_instr !== m_instr || id_pc_plus4 !== m_pc4 || id_valid !== m_valid) begin n_fail++; $display("FAIL rnd_ifid: cycle %0d got %h %h %b want %h %h %b", i, id_instr, id_pc_plus4, id_valid, m_instr, m_pc4, m_valid); end
            n_checks++; if (epc !== m_epc || irq_ack !== m_iack || exc_ack !== m_eack) begin n_fail++; $display("FAIL rnd_trap: cycle %0d got epc %h ia %b ea %b want %h %b %b", i, epc, irq_ack, exc_ack, m_epc, m_iack, m_eack); end
        end
        clr_inputs();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = $urandom();
        m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_epc = 0; m_iack = 0; m_eack = 0;
        clr_inputs();
        test_reset();
        test_stall();
        test_jump_jr();
        test_jr_no_kernel();
        test_irq();
        test_exc();
        test_branch_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Instruction-fetch sequencer for the pipelined CPU. Owns the PC, drives the instruction ROM address, and holds the IF/ID pipeline register.
- Arbitrates next-PC among these sources: sequential, branch, jump, jr, interrupt and exception.
- Applies stalls and flushes, and generates the EPC and interrupt/exception acknowledges.
- Enforces the kernel bit (PC[31]).

Parameters:
- RESET_VEC, 32'h8000_0000, PC after reset.
- IRQ_VEC, 32'h8000_0004, interrupt entry.
- EXC_VEC, 32'h8000_0008, exception entry.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- rom_addr  out  32  fetch address to ROM; equals pc, combinational.
- rom_data  in  32  instruction word from ROM, same cycle.
- stall  in  1  load-use hazard; hold PC and IF/ID.
- branch_taken  in  1  branch resolved taken in ID.
- branch_target  in  32  branch target computed in ID.
- jump  in  1  J/JAL in ID.
- jump_index  in  26  instr[25:0] of J/JAL.
- jr  in  1  JR/JALR in ID.
- jr_target  in  32  register value for JR/JALR.
- irq  in  1  level-sensitive timer/UART interrupt request.
- exc  in  1  undefined instruction detected in ID.
- id_instr  out  32  IF/ID instruction.
- id_pc_plus4  out  32  IF/ID PC+4.
- id_valid  out  1  IF/ID holds a real instruction.
- epc  out  32  return address captured on irq/exc.
- irq_ack  out  1  one-cycle pulse, interrupt taken.
- exc_ack  out  1  one-cycle pulse, exception taken.
- kernel  out  1  equals pc[31].

Behaviour:
- Reset (synchronous; wins over everything, including mid-stall or mid-redirect):
  - pc=RESET_VEC.
  - id_instr=0, id_pc_plus4=0, id_valid=0.
  - epc=0, irq_ack=0, exc_ack=0.
- Fetch: the ROM is combinational, so fetch latency is 0 cycles. The instruction at pc appears at id_* one edge later.
- Next-PC priority, evaluated each cycle:
  1. exc: next=EXC_VEC. Taken even if stall=1. Branch, jump and jr are ignored that cycle.
  2. irq: taken only if kernel=0, stall=0, and branch_taken, jump and jr are all 0. Otherwise it is deferred (level held by the source). next=IRQ_VEC.
  3. jr: next={pc[31] & jr_target[31], jr_target[30:0]}. The kernel bit may be cleared by jr, never set.
  4. jump: next={id_pc_plus4[31:28], jump_index, 2'b00}.
  5. branch_taken: next={id_pc_plus4[31], branch_target[30:0]}.
  6. stall: pc and IF/ID hold.
  7. default: next=pc+4, with bit 31 preserved (the add wraps within [30:0]). IF/ID <= {rom_data, pc+4, 1}.
- Redirect (cases 1–5):
  - pc<=next.
  - IF/ID flushed to id_instr=0, id_pc_plus4=0, id_valid=0.
  - Redirect overrides stall.
  - Exactly one fetch bubble per redirect; no delay slot.
- EPC, written only on exc or irq:
  - If id_valid=1: epc <= id_pc_plus4-4. The ID instruction is discarded and is resumed by the handler.
  - Else: epc <= pc.
  - epc holds otherwise.
- Acks: irq_ack/exc_ack are registered and high for exactly the cycle after the redirect edge. Simultaneous exc+irq gives exc_ack only; the irq stays pending.
- Kernel mode: while kernel=1, irq is masked. Leaving kernel mode happens only via jr to a target with bit31=0.
- Boundaries:
  - Consecutive redirects each flush.
  - Stall with id_valid=0 holds the bubble.
  - pc+4 at 32'h7FFF_FFFC wraps to 32'h0000_0000 (bit31 unchanged).
  - rom_addr is never gated; it always equals pc.

Test Plan:
- Reset: assert reset 2 cycles, release → pc=0x80000000; id_valid=0. After one edge, id_instr=ROM[0], id_pc_plus4=0x80000004.
- Sequential + stall: user pc=0x00000100, stall high 2 cycles → pc stays 0x100 and IF/ID unchanged. Release → pc=0x104 next edge.
- Jump/jr, kernel exit: in kernel, jump_index=26'h2F with id_pc_plus4=0x80000004 → pc=0x800000BC, id_valid=0. Then jr_target=0x0000005C → pc=0x0000005C, kernel=0.
- jr cannot enter kernel: user mode, jr_target=0x80000010 → pc=0x00000010, kernel=0.
- Interrupt, masking and deferral:
  - irq in user mode with id_valid=1, id_pc_plus4=0x108, no ID control flow → pc=0x80000004, epc=0x104, irq_ack pulse 1 cycle, id_valid=0.
  - irq held while kernel=1 → no ack.
  - irq with jump same cycle → jump taken; irq taken the following cycle.
- Exception priority: exc+irq+stall same cycle, id_pc_plus4=0x200 → pc=0x80000008, epc=0x1FC, exc_ack=1, irq_ack=0. Reset asserted during the ack cycle → all outputs return to reset values next edge.
